// File: rtl/csr_file.sv
// csr_file: LoongArch architectural CSR file with constant timer, interrupt request and LLbit.
// Optional feature macro CSR_RD_BYPASS_EN forwards a same-cycle writeback CSR write to the read port.
module csr_file #(
  parameter int TIMER_W = 32,
  parameter int HWI_N   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_csr_write_en,
  input  logic [13:0]      wb_csr_write_addr,
  input  logic [31:0]      wb_csr_write_data,
  input  logic             wb_LLbit_write_en,
  input  logic             wb_LLbit_write_data,
  input  logic [13:0]      csr_read_addr,
  output logic [31:0]      csr_read_data,
  input  logic             excp_valid,
  input  logic [5:0]       excp_ecode,
  input  logic [8:0]       excp_esubcode,
  input  logic [31:0]      excp_pc,
  input  logic             excp_badv_valid,
  input  logic [31:0]      excp_badv,
  input  logic             ertn_valid,
  input  logic [HWI_N-1:0] hw_int,
  output logic [31:0]      eentry,
  output logic [31:0]      era,
  output logic             irq_pending,
  output logic [1:0]       crmd_plv,
  output logic             LLbit
);

  localparam logic [13:0] ADDR_CRMD   = 14'h000;
  localparam logic [13:0] ADDR_PRMD   = 14'h001;
  localparam logic [13:0] ADDR_ECFG   = 14'h004;
  localparam logic [13:0] ADDR_ESTAT  = 14'h005;
  localparam logic [13:0] ADDR_ERA    = 14'h006;
  localparam logic [13:0] ADDR_BADV   = 14'h007;
  localparam logic [13:0] ADDR_EENTRY = 14'h00C;
  localparam logic [13:0] ADDR_SAVE0  = 14'h030;
  localparam logic [13:0] ADDR_SAVE1  = 14'h031;
  localparam logic [13:0] ADDR_SAVE2  = 14'h032;
  localparam logic [13:0] ADDR_SAVE3  = 14'h033;
  localparam logic [13:0] ADDR_TID    = 14'h040;
  localparam logic [13:0] ADDR_TCFG   = 14'h041;
  localparam logic [13:0] ADDR_TVAL   = 14'h042;
  localparam logic [13:0] ADDR_TICLR  = 14'h044;
  localparam logic [13:0] ADDR_LLBCTL = 14'h060;

  logic [8:0]       crmd_q, crmd_d;
  logic [2:0]       prmd_q, prmd_d;
  logic [12:0]      ecfg_q, ecfg_d;
  logic [1:0]       estat_sw_q, estat_sw_d;
  logic [HWI_N-1:0] estat_hwi_q, estat_hwi_d;
  logic             timer_flag_q, timer_flag_d;
  logic [5:0]       ecode_q, ecode_d;
  logic [8:0]       esub_q, esub_d;
  logic [31:0]      era_q, era_d;
  logic [31:0]      badv_q, badv_d;
  logic [25:0]      eentry_q, eentry_d;
  logic [31:0]      save_q [4];
  logic [31:0]      save_d [4];
  logic [31:0]      tid_q, tid_d;
  logic [31:0]      tcfg_q, tcfg_d;
  logic [TIMER_W-1:0] tval_q, tval_d;
  logic             llbit_q, llbit_d;
  logic             klo_q, klo_d;

  logic        wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv, wr_eentry;
  logic        wr_save, wr_tid, wr_tcfg, wr_ticlr, wr_llbctl;
  logic        timer_expire;
  logic [7:0]  hwi_is;
  logic [12:0] is_vec;
  logic [31:0] estat_rd;
  logic [31:0] read_raw;

  assign wr_crmd   = wb_csr_write_en && (wb_csr_write_addr == ADDR_CRMD);
  assign wr_prmd   = wb_csr_write_en && (wb_csr_write_addr == ADDR_PRMD);
  assign wr_ecfg   = wb_csr_write_en && (wb_csr_write_addr == ADDR_ECFG);
  assign wr_estat  = wb_csr_write_en && (wb_csr_write_addr == ADDR_ESTAT);
  assign wr_era    = wb_csr_write_en && (wb_csr_write_addr == ADDR_ERA);
  assign wr_badv   = wb_csr_write_en && (wb_csr_write_addr == ADDR_BADV);
  assign wr_eentry = wb_csr_write_en && (wb_csr_write_addr == ADDR_EENTRY);
  assign wr_save   = wb_csr_write_en && (wb_csr_write_addr[13:2] == ADDR_SAVE0[13:2]);
  assign wr_tid    = wb_csr_write_en && (wb_csr_write_addr == ADDR_TID);
  assign wr_tcfg   = wb_csr_write_en && (wb_csr_write_addr == ADDR_TCFG);
  assign wr_ticlr  = wb_csr_write_en && (wb_csr_write_addr == ADDR_TICLR);
  assign wr_llbctl = wb_csr_write_en && (wb_csr_write_addr == ADDR_LLBCTL);

  // Next state: the writeback write is applied first, then the commit-point
  // exception/ertn updates are overlaid since they are younger.
  always_comb begin
    crmd_d       = crmd_q;
    prmd_d       = prmd_q;
    ecfg_d       = ecfg_q;
    estat_sw_d   = estat_sw_q;
    estat_hwi_d  = hw_int;
    timer_flag_d = timer_flag_q;
    ecode_d      = ecode_q;
    esub_d       = esub_q;
    era_d        = era_q;
    badv_d       = badv_q;
    eentry_d     = eentry_q;
    save_d       = save_q;
    tid_d        = tid_q;
    tcfg_d       = tcfg_q;
    tval_d       = tval_q;
    llbit_d      = llbit_q;
    klo_d        = klo_q;
    timer_expire = 1'b0;

    if (wr_crmd)   crmd_d     = wb_csr_write_data[8:0];
    if (wr_prmd)   prmd_d     = wb_csr_write_data[2:0];
    if (wr_ecfg)   ecfg_d     = {wb_csr_write_data[12:11], 1'b0, wb_csr_write_data[9:0]};
    if (wr_estat)  estat_sw_d = wb_csr_write_data[1:0];
    if (wr_era)    era_d      = wb_csr_write_data;
    if (wr_badv)   badv_d     = wb_csr_write_data;
    if (wr_eentry) eentry_d   = wb_csr_write_data[31:6];
    if (wr_save)   save_d[wb_csr_write_addr[1:0]] = wb_csr_write_data;
    if (wr_tid)    tid_d      = wb_csr_write_data;
    if (wr_tcfg)   tcfg_d     = wb_csr_write_data;
    if (wr_llbctl) begin
      if (wb_csr_write_data[1]) llbit_d = 1'b0;
      if (wb_csr_write_data[2]) klo_d   = 1'b1;
    end

    // Expiry reloads in periodic mode, otherwise it disarms the timer at zero.
    if (wr_tcfg) begin
      tval_d = {wb_csr_write_data[TIMER_W-1:2], 2'b00};
    end else if (tcfg_q[0] && (tval_q != '0)) begin
      if (tval_q == TIMER_W'(1)) begin
        timer_expire = 1'b1;
        if (tcfg_q[1]) begin
          tval_d = {tcfg_q[TIMER_W-1:2], 2'b00};
        end else begin
          tval_d    = '0;
          tcfg_d[0] = 1'b0;
        end
      end else begin
        tval_d = tval_q - TIMER_W'(1);
      end
    end

    if (wr_ticlr && wb_csr_write_data[0]) timer_flag_d = 1'b0;
    if (timer_expire)                     timer_flag_d = 1'b1;

    if (wb_LLbit_write_en) llbit_d = wb_LLbit_write_data;

    if (excp_valid) begin
      prmd_d       = crmd_d[2:0];
      crmd_d[2:0]  = 3'b000;
      era_d        = excp_pc;
      ecode_d      = excp_ecode;
      esub_d       = excp_esubcode;
      if (excp_badv_valid) badv_d = excp_badv;
    end else if (ertn_valid) begin
      crmd_d[2:0] = prmd_d;
      klo_d       = 1'b0;
      llbit_d     = klo_q ? llbit_q : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crmd_q       <= 9'h008;
      prmd_q       <= '0;
      ecfg_q       <= '0;
      estat_sw_q   <= '0;
      estat_hwi_q  <= '0;
      timer_flag_q <= 1'b0;
      ecode_q      <= '0;
      esub_q       <= '0;
      era_q        <= '0;
      badv_q       <= '0;
      eentry_q     <= '0;
      save_q       <= '{default: '0};
      tid_q        <= '0;
      tcfg_q       <= '0;
      tval_q       <= '0;
      llbit_q      <= 1'b0;
      klo_q        <= 1'b0;
    end else begin
      crmd_q       <= crmd_d;
      prmd_q       <= prmd_d;
      ecfg_q       <= ecfg_d;
      estat_sw_q   <= estat_sw_d;
      estat_hwi_q  <= estat_hwi_d;
      timer_flag_q <= timer_flag_d;
      ecode_q      <= ecode_d;
      esub_q       <= esub_d;
      era_q        <= era_d;
      badv_q       <= badv_d;
      eentry_q     <= eentry_d;
      save_q       <= save_d;
      tid_q        <= tid_d;
      tcfg_q       <= tcfg_d;
      tval_q       <= tval_d;
      llbit_q      <= llbit_d;
      klo_q        <= klo_d;
    end
  end

  // Hardware interrupt lines occupy IS[9:2]; lines beyond eight are not architected.
  always_comb begin
    hwi_is = '0;
    for (int i = 0; (i < HWI_N) && (i < 8); i++) hwi_is[i] = estat_hwi_q[i];
  end

  assign is_vec   = {1'b0, timer_flag_q, 1'b0, hwi_is, estat_sw_q};
  assign estat_rd = {1'b0, esub_q, ecode_q, 3'b000, is_vec};

  always_comb begin
    read_raw = '0;
    case (csr_read_addr)
      ADDR_CRMD:   read_raw = {23'b0, crmd_q};
      ADDR_PRMD:   read_raw = {29'b0, prmd_q};
      ADDR_ECFG:   read_raw = {19'b0, ecfg_q};
      ADDR_ESTAT:  read_raw = estat_rd;
      ADDR_ERA:    read_raw = era_q;
      ADDR_BADV:   read_raw = badv_q;
      ADDR_EENTRY: read_raw = {eentry_q, 6'b0};
      ADDR_SAVE0:  read_raw = save_q[0];
      ADDR_SAVE1:  read_raw = save_q[1];
      ADDR_SAVE2:  read_raw = save_q[2];
      ADDR_SAVE3:  read_raw = save_q[3];
      ADDR_TID:    read_raw = tid_q;
      ADDR_TCFG:   read_raw = tcfg_q;
      ADDR_TVAL:   read_raw = 32'(tval_q);
      ADDR_LLBCTL: read_raw = {29'b0, klo_q, 1'b0, llbit_q};
      default:     read_raw = '0;
    endcase
  end

`ifdef CSR_RD_BYPASS_EN
  // TVAL, TICLR and LLBCTL get a zero mask so they are never forwarded.
  function automatic logic [31:0] write_mask(input logic [13:0] addr);
    case (addr)
      ADDR_CRMD:   return 32'h0000_01FF;
      ADDR_PRMD:   return 32'h0000_0007;
      ADDR_ECFG:   return 32'h0000_1BFF;
      ADDR_ESTAT:  return 32'h0000_0003;
      ADDR_EENTRY: return 32'hFFFF_FFC0;
      ADDR_ERA, ADDR_BADV, ADDR_SAVE0, ADDR_SAVE1, ADDR_SAVE2, ADDR_SAVE3,
      ADDR_TID, ADDR_TCFG: return 32'hFFFF_FFFF;
      default:     return 32'h0000_0000;
    endcase
  endfunction

  logic [31:0] byp_mask;
  assign byp_mask = (wb_csr_write_en && (wb_csr_write_addr == csr_read_addr))
                    ? write_mask(csr_read_addr) : 32'h0;
  assign csr_read_data = (read_raw & ~byp_mask) | (wb_csr_write_data & byp_mask);
`else
  assign csr_read_data = read_raw;
`endif

  assign eentry      = {eentry_q, 6'b0};
  assign era         = era_q;
  assign crmd_plv    = crmd_q[1:0];
  assign LLbit       = llbit_q;
  assign irq_pending = crmd_q[2] & (|(is_vec & ecfg_q));

endmodule

// File: doc/csr_file.md
Name: csr_file

Overview:
- Architectural CSR file and LLbit holder for the LoongArch core.
- Consumes the writeback-stage CSR and LLbit write streams.
- Serves combinational CSR reads to the execute stage.
- Applies exception-entry and ertn state changes from the commit point.
- Runs the constant timer and produces the interrupt request, exception entry address and return address for the pipeline controller.

Parameters:
- TIMER_W, 32, width of TVAL down-counter (InitVal field = TIMER_W-2 bits)
- HWI_N, 8, number of hardware interrupt lines (ESTAT.IS[9:2])

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb_csr_write_en  in  1  CSR write strobe from writeback
- wb_csr_write_addr  in  14  CSR number
- wb_csr_write_data  in  32  write data
- wb_LLbit_write_en  in  1  LLbit write strobe (ll/sc)
- wb_LLbit_write_data  in  1  LLbit value
- csr_read_addr  in  14  read CSR number
- csr_read_data  out  32  read data, combinational
- excp_valid  in  1  exception commit this cycle
- excp_ecode  in  6  Ecode
- excp_esubcode  in  9  EsubCode
- excp_pc  in  32  faulting PC
- excp_badv_valid  in  1  BADV update required
- excp_badv  in  32  bad virtual address
- ertn_valid  in  1  ertn commit this cycle
- hw_int  in  HWI_N  level hardware interrupts
- eentry  out  32  {EENTRY[31:6],6'b0}
- era  out  32  ERA
- irq_pending  out  1  interrupt to take
- crmd_plv  out  2  current privilege level
- LLbit  out  1  LL bit

Behaviour:
- Map (addr: writable mask; reset value):
  - CRMD 0x0: 0x1FF; 0x00000008 (DA=1)
  - PRMD 0x1: 0x7; 0
  - ECFG 0x4: 0x1BFF; 0
  - ESTAT 0x5: 0x3; 0
  - ERA 0x6: all bits; 0
  - BADV 0x7: all bits; 0
  - EENTRY 0xC: 0xFFFFFFC0; 0
  - SAVE0-3 0x30-0x33: all bits; 0
  - TID 0x40: all bits; 0
  - TCFG 0x41: all bits; 0
  - TVAL 0x42: read-only; 0
  - TICLR 0x44: write-only, reads 0
  - LLBCTL 0x60: see below
- Unmapped addresses: reads return 0, writes are ignored. A write updates only masked bits.
- CSR write latency: 1 cycle; the new value is visible on csr_read_data the next cycle.
- ESTAT.IS[9:2] sampled from hw_int every cycle (1-cycle latency). IS[11] = timer flag. All other IS bits read 0.
- irq_pending = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]), combinational from registers.
- Same-cycle ordering: the wb write is older than the excp/ertn commit. Apply the wb write first, then overlay the excp/ertn field updates. Overlapping fields take the excp/ertn value.
- excp_valid:
  - PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE
  - CRMD.PLV<=0, CRMD.IE<=0
  - ERA<=excp_pc
  - ESTAT[21:16]<=ecode, ESTAT[30:22]<=esubcode
  - BADV<=excp_badv if excp_badv_valid
- ertn_valid: CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE.
- excp_valid together with ertn_valid: excp wins; ertn is ignored.
- Timer:
  - A TCFG write loads TVAL<={InitVal,2'b00}.
  - Otherwise, when TCFG.En=1 and TVAL!=0, TVAL decrements by 1 per cycle.
  - On the transition TVAL 1->0: set IS[11]. If TCFG.Periodic=1, reload TVAL<={InitVal,2'b00}; else TCFG.En<=0 and TVAL holds 0.
  - TICLR write with bit0=1 clears IS[11]. If expiry occurs in the same cycle, set wins.
- LLBCTL reads {29'b0, KLO, 1'b0, LLbit}:
  - Write bit1 (WCLLB)=1 clears LLbit.
  - Write bit2 sets KLO.
- LLbit priority:
  1. rst -> 0
  2. ertn_valid (without excp) -> LLbit<=0 unless KLO=1; KLO<=0 always
  3. wb_LLbit_write_en -> wb_LLbit_write_data
  4. WCLLB
- Reset: all outputs and registers are driven to the reset values above:
  - eentry=0, era=0, irq_pending=0, crmd_plv=0, LLbit=0, csr_read_data=0 for addr 0x42
  - Reset mid-timer abandons the count.

Optional Feature:
- Macro: CSR_RD_BYPASS_EN.
- Defined: if wb_csr_write_en is set and wb_csr_write_addr==csr_read_addr, csr_read_data = (old & ~mask) | (wdata & mask) for that CSR, so the write is visible in the same cycle.
  - TVAL, TICLR and LLBCTL are never bypassed.
  - excp/ertn same-cycle updates are not bypassed.
- Undefined: reads always return registered state.

Test Plan:
- Reset, then read CRMD -> 0x00000008; ESTAT, ERA, TVAL -> 0; LLbit=0; irq_pending=0.
- Write CRMD=0xFFFFFFFF; read next cycle -> 0x000001FF, crmd_plv=3. With CSR_RD_BYPASS_EN, same-cycle read -> 0x1FF.
- CRMD=0x7, excp_valid, ecode=0x0B, pc=0x1C000100 -> next cycle CRMD.PLV=0, IE=0, PRMD=0x7, ERA=0x1C000100, ESTAT[21:16]=0x0B. Then ertn -> CRMD[2:0]=0x7.
- TCFG=0x0000000B (InitVal=2, En, Periodic) -> TVAL=8, counts to 0 after 8 cycles, IS[11]=1, reload 8. ECFG=0x800, CRMD.IE=1 -> irq_pending=1. TICLR=1 -> IS[11]=0.
- wb_LLbit_write_en=1, data=1 -> LLbit=1. ertn with KLO=0 -> LLbit=0. Repeat with KLO=1 -> LLbit stays 1, KLO cleared.
- Same cycle: wb write ERA=0x1234 and excp_valid pc=0x5678 -> ERA=0x5678.
